cfglut5_chain_loader: RTL and testbench
=======================================

Name: cfglut5_chain_loader

Overview:
- Sequences run-time reprogramming of a daisy-chain of CHAIN_LEN CFGLUT5 reconfigurable LUTs: each LUT holds a 32-bit truth table that is shifted serially via CDI/CE and returned on CDO.
- Accepts 32-bit truth-table words over a valid/ready handshake, drives the shared CE and the chain's CDI, and captures the old contents returning on the last LUT's CDO as readback words.
- Sits between a configuration master (bench, fault-injection sequencer, soft CPU) and the CFGLUT5 chain. All LUTs share CLK.

Parameters:
- CHAIN_LEN, 1, number of chained CFGLUT5 cells (legal 1..64); one session = CHAIN_LEN words.

Ports:
- CLK  input  1  single clock, rising edge; also clocks the CFGLUT5 chain.
- RST  input  1  synchronous, active-high reset.
- CFG_VALID  input  1  CFG_DATA valid.
- CFG_READY  output  1  controller accepts a word this cycle.
- CFG_DATA  input  32  truth-table word, MSB shifted first.
- LUT_CE  output  1  shift enable to every LUT in the chain.
- LUT_CDI  output  1  serial data into LUT 0.
- LUT_CDO  input  1  serial data out of LUT CHAIN_LEN-1.
- RB_VALID  output  1  one-cycle pulse: RB_DATA holds a completed readback word.
- RB_DATA  output  32  old truth table shifted out, MSB first.
- BUSY  output  1  session in progress.
- DONE  output  1  one-cycle pulse: final word of the session is fully shifted.

Behaviour:
- States: IDLE, SHIFT, WAIT. Registers: data_sr[31:0], rb_sr[31:0], bit_cnt[4:0], word_cnt (clog2(CHAIN_LEN+1) bits).
- Reset (edge with RST=1): state=IDLE, CFG_READY=1, LUT_CE=0, LUT_CDI=0, RB_VALID=0, RB_DATA=0, BUSY=0, DONE=0, all counters 0. RST overrides every other event.
- LUT_CE=1 exactly while state==SHIFT. LUT_CDI=data_sr[31]. Neither output has combinational paths from inputs.
- Accept: a word is accepted on an edge with CFG_VALID & CFG_READY. data_sr<=CFG_DATA, bit_cnt<=0, state<=SHIFT.
- CFG_READY is high:
  - in IDLE;
  - in WAIT;
  - in SHIFT when bit_cnt==31 and word_cnt<CHAIN_LEN-1 (back-to-back accept).
- SHIFT edge, every cycle in SHIFT:
  - data_sr<=data_sr<<1.
  - rb_sr<={rb_sr[30:0], LUT_CDO}, sampling the pre-shift CDO.
  - bit_cnt++.
- End of word (SHIFT edge with bit_cnt==31):
  - RB_DATA<={rb_sr[30:0], LUT_CDO}, with RB_VALID=1 the next cycle.
  - If this was word CHAIN_LEN-1: DONE=1 the next cycle (same cycle as the last RB_VALID), state<=IDLE, word_cnt<=0.
  - Else word_cnt++. Next state is SHIFT with the new word loaded if a word was accepted on this same edge, otherwise WAIT.
- Latency: word accepted at edge E0 -> LUT_CE high for cycles after E0..E31 -> shifts complete at E32 -> RB_VALID pulse after E32.
- Full session: back-to-back inputs give exactly 32*CHAIN_LEN consecutive CE cycles.
- WAIT stall: LUT_CE=0 and chain contents are frozen; the stall has no time limit and the session resumes on the next accept.
- Ordering:
  - Word k (k=0 first) ends in LUT CHAIN_LEN-1-k.
  - Readback word k = previous contents of LUT CHAIN_LEN-1-k.
- BUSY=1 from the cycle after the first accept through the cycle carrying DONE; BUSY=0 in IDLE.
- CFG_VALID while CFG_READY=0 is ignored; CFG_DATA is not sampled.
- RB_VALID has no backpressure; the consumer must take it in the pulse cycle.
- Reset mid-session:
  - CE drops in the cycle after the reset edge.
  - The chain holds a partial shift; neither RB_VALID nor DONE is issued for the aborted session.
  - The next accepted word starts a new session at word 0.

Test Plan:
- CHAIN_LEN=1, LUT model preloaded 32'h12345678, send 32'hA5A50F0F at E0 -> CE high for exactly 32 cycles; after E32 RB_DATA=32'h12345678 with RB_VALID=DONE=1 for one cycle; LUT INIT=32'hA5A50F0F.
- CHAIN_LEN=2, LUTs preloaded {LUT0=32'h11111111, LUT1=32'h22222222}, words 32'hAAAA0000 then 32'h0000BBBB presented back-to-back -> 64 contiguous CE cycles; RB words 32'h22222222 then 32'h11111111; final LUT1=32'hAAAA0000, LUT0=32'h0000BBBB; DONE after edge 64.
- CHAIN_LEN=2, second word delayed 10 cycles -> state WAIT, CE=0 and BUSY=1 for 10 cycles; final LUT contents identical to the back-to-back case.
- CFG_VALID held high with 32'hFFFFFFFF during cycles 5..20 of a shift -> no extra accept; CFG_READY=0 throughout; loaded word unchanged.
- RST asserted at bit_cnt==16 -> next cycle CE=0, BUSY=0, CFG_READY=1; no RB_VALID or DONE; a new load of 32'hDEADBEEF then completes normally in 32 CE cycles.
- RST held high together with CFG_VALID=1 -> no accept; all outputs remain at their reset values.

Source files
------------

// File: rtl/cfglut5_chain_loader.sv
// cfglut5_chain_loader: streams 32-bit truth tables into a daisy chain of
// CFGLUT5 cells over CE/CDI and collects the displaced contents from CDO.
// Word k of a session lands in LUT CHAIN_LEN-1-k; readback word k is the
// previous contents of that same LUT.
module cfglut5_chain_loader #(
  parameter int unsigned CHAIN_LEN = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [31:0] CFG_DATA,
  output logic        LUT_CE,
  output logic        LUT_CDI,
  input  logic        LUT_CDO,
  output logic        RB_VALID,
  output logic [31:0] RB_DATA,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned WCW = $clog2(CHAIN_LEN + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(CHAIN_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]     r_state;
  logic [31:0]    r_data_sr;
  logic [31:0]    r_rb_sr;
  logic [4:0]     r_bit_cnt;
  logic [WCW-1:0] r_word_cnt;
  logic           r_rb_valid;
  logic [31:0]    r_rb_data;
  logic           r_done;

  logic           w_end_word;
  logic           w_last_word;
  logic           w_ready;
  logic           w_accept;

  assign w_end_word  = (r_state == SHIFT) && (r_bit_cnt == 5'd31);
  assign w_last_word = (r_word_cnt == LAST_WORD);

  // Ready decode: open while idle or stalled, and on the final bit of a
  // non-final word so the next word can follow without a gap.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      WAIT:    w_ready = 1'b1;
      SHIFT:   w_ready = w_end_word && (r_word_cnt < LAST_WORD);
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept = CFG_VALID && w_ready;

  // Session sequencer and shift datapath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_data_sr  <= '0;
      r_rb_sr    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE, WAIT: begin
          if (w_accept) begin
            r_data_sr <= CFG_DATA;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_data_sr <= {r_data_sr[30:0], 1'b0};
          // CDO is sampled before this edge shifts the chain.
          r_rb_sr   <= {r_rb_sr[30:0], LUT_CDO};
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == 5'd31) begin
            r_rb_data  <= {r_rb_sr[30:0], LUT_CDO};
            r_rb_valid <= 1'b1;
            if (w_last_word) begin
              r_done     <= 1'b1;
              r_word_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_word_cnt <= r_word_cnt + WCW'(1);
              if (w_accept) begin
                r_data_sr <= CFG_DATA;
                r_bit_cnt <= '0;
                r_state   <= SHIFT;
              end else begin
                r_state <= WAIT;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign CFG_READY = w_ready;
  assign LUT_CE    = (r_state == SHIFT);
  assign LUT_CDI   = r_data_sr[31];
  assign RB_VALID  = r_rb_valid;
  assign RB_DATA   = r_rb_data;
  assign DONE      = r_done;
  // The DONE cycle already sits in IDLE but still belongs to the session.
  assign BUSY      = (r_state != IDLE) || r_done;

endmodule

// File: tb/tb_cfglut5_chain_loader.sv
// Bench for cfglut5_chain_loader: two instances (chain of 1 and chain of 2)
// driving behavioural CFGLUT5 shift models.
module tb_cfglut5_chain_loader;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_data;
  logic        v1, v2;
  logic        rdy1, ce1, cdi1, cdo1, rbv1, busy1, done1;
  logic        rdy2, ce2, cdi2, cdo2, rbv2, busy2, done2;
  logic [31:0] rbd1, rbd2;

  // LUT models
  logic        pre_en;
  logic [31:0] pre_l1, pre_l20, pre_l21;
  logic [31:0] l1, l20, l21;

  logic        sel;
  logic        m_ready, m_ce, m_rbv, m_busy, m_done;
  logic [31:0] m_rbd;

  int n_chk = 0;
  int n_pass = 0;

  cfglut5_chain_loader #(.CHAIN_LEN(1)) u_dut1 (
    .CLK(clk), .RST(rst), .CFG_VALID(v1), .CFG_READY(rdy1), .CFG_DATA(cfg_data),
    .LUT_CE(ce1), .LUT_CDI(cdi1), .LUT_CDO(cdo1), .RB_VALID(rbv1), .RB_DATA(rbd1),
    .BUSY(busy1), .DONE(done1)
  );

  cfglut5_chain_loader #(.CHAIN_LEN(2)) u_dut2 (
    .CLK(clk), .RST(rst), .CFG_VALID(v2), .CFG_READY(rdy2), .CFG_DATA(cfg_data),
    .LUT_CE(ce2), .LUT_CDI(cdi2), .LUT_CDO(cdo2), .RB_VALID(rbv2), .RB_DATA(rbd2),
    .BUSY(busy2), .DONE(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CFGLUT5 behaviour: INIT shifts left on CE, CDI enters at bit 0, CDO = bit 31.
  always @(posedge clk) begin
    if (pre_en) begin
      l1  <= pre_l1;
      l20 <= pre_l20;
      l21 <= pre_l21;
    end else begin
      if (ce1) l1 <= {l1[30:0], cdi1};
      if (ce2) begin
        l20 <= {l20[30:0], cdi2};
        l21 <= {l21[30:0], l20[31]};
      end
    end
  end
  assign cdo1 = l1[31];
  assign cdo2 = l21[31];

  assign m_ready = sel ? rdy2 : rdy1;
  assign m_ce    = sel ? ce2 : ce1;
  assign m_rbv   = sel ? rbv2 : rbv1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_done  = sel ? done2 : done1;
  assign m_rbd   = sel ? rbd2 : rbd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    pre_l1 = a; pre_l20 = b; pre_l21 = c;
    pre_en = 1'b1;
    step();
    pre_en = 1'b0;
  endtask

  task automatic set_valid(input logic x);
    v1 = !sel && x;
    v2 = sel && x;
  endtask

  // Runs one session; second word presented immediately (gap=0) or after
  // gap observed WAIT cycles.
  task automatic run_session(input logic s, input int nwords, input logic [31:0] w0,
                             input logic [31:0] w1, input int gap,
                             output int ce_n, output int rb_n, output logic [31:0] rb0,
                             output logic [31:0] rb1, output int done_n, output int done_ok,
                             output int stall, output int delta);
    int sent;
    int first_it;
    logic acc;
    logic fin;
    sel = s;
    ce_n = 0; rb_n = 0; rb0 = '0; rb1 = '0; done_n = 0; done_ok = 0; stall = 0;
    delta = -1; sent = 0; first_it = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (sent < nwords && (sent == 0 || stall >= gap)) begin
        cfg_data = (sent == 0) ? w0 : w1;
        set_valid(1'b1);
      end else begin
        set_valid(1'b0);
      end
      acc = (v1 || v2) && m_ready;
      step();
      if (acc) begin
        sent++;
        if (sent == 1) first_it = cyc;
      end
      if (m_ce) ce_n++;
      if (sent > 0 && !m_ce && m_busy && !m_done) stall++;
      if (m_rbv) begin
        if (rb_n == 0) rb0 = m_rbd;
        else rb1 = m_rbd;
        rb_n++;
      end
      if (m_done) begin
        done_n++;
        if (m_rbv && rb_n == nwords) done_ok = 1;
        delta = cyc - first_it;
        fin = 1'b1;
      end
    end
    set_valid(1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (m_rbv) rb_n++;
      if (m_done) done_n++;
      if (m_ce) ce_n++;
    end
  endtask

  typedef struct {
    logic [31:0] pre;
    logic [31:0] word;
    logic [31:0] exp_rb;
    logic [31:0] exp_lut;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int ce_n, rb_n, done_n, done_ok, stall, delta, bad;
    logic [31:0] rb0, rb1;
    logic fin;

    vecs[0] = '{pre: 32'h12345678, word: 32'hA5A50F0F, exp_rb: 32'h12345678, exp_lut: 32'hA5A50F0F};
    vecs[1] = '{pre: 32'h00000000, word: 32'hFFFFFFFF, exp_rb: 32'h00000000, exp_lut: 32'hFFFFFFFF};
    vecs[2] = '{pre: 32'hFFFFFFFF, word: 32'h00000001, exp_rb: 32'hFFFFFFFF, exp_lut: 32'h00000001};
    vecs[3] = '{pre: 32'h80000001, word: 32'h7FFFFFFE, exp_rb: 32'h80000001, exp_lut: 32'h7FFFFFFE};

    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; sel = 1'b0; cfg_data = '0;
    pre_en = 1'b0; pre_l1 = '0; pre_l20 = '0; pre_l21 = '0;
    repeat (3) step();

    // Reset values
    chk("reset_flags1", {26'd0, rdy1, ce1, cdi1, rbv1, busy1, done1}, 32'h20);
    chk("reset_rbdata1", rbd1, 32'h0);
    chk("reset_flags2", {26'd0, rdy2, ce2, cdi2, rbv2, busy2, done2}, 32'h20);
    chk("reset_rbdata2", rbd2, 32'h0);

    // RST with CFG_VALID high: nothing accepted
    bad = 0;
    cfg_data = 32'h5A5A5A5A; v1 = 1'b1; v2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({ce1, rbv1, busy1, done1, ce2, rbv2, busy2, done2} != 8'd0 || !rdy1 || !rdy2) bad++;
    end
    rst = 1'b0; v1 = 1'b0; v2 = 1'b0;
    step();
    chk("rst_valid_outputs", 32'(bad), 32'd0);
    chk("rst_valid_no_ce", {30'd0, ce1, ce2}, 32'd0);

    // Table: CHAIN_LEN=1 single-word sessions
    foreach (vecs[i]) begin
      preload(vecs[i].pre, 32'h0, 32'h0);
      run_session(1'b0, 1, vecs[i].word, 32'h0, 0, ce_n, rb_n, rb0, rb1, done_n, done_ok,
                  stall, delta);
      chk($sformatf("v%0d_ce_cycles", i), 32'(ce_n), 32'd32);
      chk($sformatf("v%0d_rb_count", i), 32'(rb_n), 32'd1);
      chk($sformatf("v%0d_rb_data", i), rb0, vecs[i].exp_rb);
      chk($sformatf("v%0d_done_with_rb", i), 32'(done_n * 2 + done_ok), 32'd3);
      chk($sformatf("v%0d_done_latency", i), 32'(delta), 32'd32);
      chk($sformatf("v%0d_lut", i), l1, vecs[i].exp_lut);
      chk($sformatf("v%0d_busy_after", i), {31'd0, busy1}, 32'd0);
    end

    // CHAIN_LEN=2 back-to-back
    preload(32'h0, 32'h11111111, 32'h22222222);
    run_session(1'b1, 2, 32'hAAAA0000, 32'h0000BBBB, 0, ce_n, rb_n, rb0, rb1, done_n, done_ok,
                stall, delta);
    chk("b2b_ce_cycles", 32'(ce_n), 32'd64);
    chk("b2b_done_latency", 32'(delta), 32'd64);
    chk("b2b_stall", 32'(stall), 32'd0);
    chk("b2b_rb_count", 32'(rb_n), 32'd2);
    chk("b2b_rb0", rb0, 32'h22222222);
    chk("b2b_rb1", rb1, 32'h11111111);
    chk("b2b_done", 32'(done_n * 2 + done_ok), 32'd3);
    chk("b2b_lut1", l21, 32'hAAAA0000);
    chk("b2b_lut0", l20, 32'h0000BBBB);

    // CHAIN_LEN=2 with a 10-cycle stall before the second word
    preload(32'h0, 32'h11111111, 32'h22222222);
    run_session(1'b1, 2, 32'hAAAA0000, 32'h0000BBBB, 10, ce_n, rb_n, rb0, rb1, done_n,
                done_ok, stall, delta);
    chk("gap_stall_cycles", 32'(stall), 32'd10);
    chk("gap_ce_cycles", 32'(ce_n), 32'd64);
    chk("gap_done_latency", 32'(delta), 32'd74);
    chk("gap_rb0", rb0, 32'h22222222);
    chk("gap_rb1", rb1, 32'h11111111);
    chk("gap_done", 32'(done_n * 2 + done_ok), 32'd3);
    chk("gap_lut1", l21, 32'hAAAA0000);
    chk("gap_lut0", l20, 32'h0000BBBB);

    // CFG_VALID held during the shift is ignored
    sel = 1'b0;
    preload(32'h0F0F0F0F, 32'h0, 32'h0);
    cfg_data = 32'h3C3CC3C3; v1 = 1'b1;
    step();
    v1 = 1'b0;
    bad = 0; ce_n = 0; rb_n = 0; done_n = 0; rb0 = '0; fin = 1'b0;
    for (int k = 0; k < 60 && !fin; k++) begin
      if (ce1) ce_n++;
      if (rbv1) begin rb_n++; rb0 = rbd1; end
      if (done1) begin done_n++; fin = 1'b1; end
      if (k >= 5 && k <= 20) begin
        cfg_data = 32'hFFFFFFFF; v1 = 1'b1;
        if (rdy1) bad++;
      end else begin
        v1 = 1'b0;
      end
      if (!fin) step();
    end
    v1 = 1'b0;
    chk("hold_ready_low", 32'(bad), 32'd0);
    chk("hold_ce_cycles", 32'(ce_n), 32'd32);
    chk("hold_rb", rb0, 32'h0F0F0F0F);
    chk("hold_done_count", 32'(rb_n * 2 + done_n), 32'd3);
    chk("hold_lut", l1, 32'h3C3CC3C3);
    step();

    // Reset mid-word at bit_cnt==16
    preload(32'h12345678, 32'h0, 32'h0);
    cfg_data = 32'hA5A50F0F; v1 = 1'b1;
    step();
    v1 = 1'b0;
    ce_n = 0;
    for (int k = 0; k <= 16; k++) begin
      if (ce1) ce_n++;
      if (k == 16) rst = 1'b1;
      step();
    end
    chk("rst_mid_ce_before", 32'(ce_n), 32'd17);
    chk("rst_mid_after", {29'd0, ce1, busy1, rdy1}, 32'd1);
    rst = 1'b0;
    rb_n = 0; done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (rbv1) rb_n++;
      if (done1) done_n++;
      if (ce1) rb_n++;
      step();
    end
    chk("rst_mid_silent", 32'(rb_n + done_n), 32'd0);
    // LUT now holds 17 bits of the aborted word: {P[14:0], W[31:15]}
    chk("rst_mid_partial", l1, 32'hACF14B4A);
    run_session(1'b0, 1, 32'hDEADBEEF, 32'h0, 0, ce_n, rb_n, rb0, rb1, done_n, done_ok,
                stall, delta);
    chk("rst_reload_ce", 32'(ce_n), 32'd32);
    chk("rst_reload_rb", rb0, 32'hACF14B4A);
    chk("rst_reload_done", 32'(done_n * 2 + done_ok), 32'd3);
    chk("rst_reload_lut", l1, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
